// File: rtl/smem_output_collector.sv
// smem_output_collector: consumer end of the SMEM result stream.
// Grants permit to the producer, parses per-read groups (one header beat followed by mem
// beats carrying two mems each), buffers every beat in a FIFO and drains the FIFO as
// addressed 512-bit line writes. It also drives stall back to the producer and reports
// counters, completion and sticky errors.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               1-cycle pulse that arms a new batch (accepted in IDLE/DONE only)
//   base_addr           line-0 byte address, 64B aligned; sampled on start
//   batch_size          number of reads expected; sampled on start
//   output_request      producer has results ready
//   output_permit       grant to the producer
//   output_data         beat payload
//   output_valid        beat valid; there is no ready, so the beat must be absorbed
//   output_finish       producer has exhausted the batch (level)
//   stall               backpressure to the producer
//   wr_valid/ready      line write handshake toward host memory
//   wr_addr, wr_data    line write address and data
//   reads_seen          number of headers parsed
//   mems_seen           number of mem entries parsed
//   done                batch fully written
//   err                 sticky {overflow, seq_mismatch, unexpected_valid}
module smem_output_collector #(
  parameter int unsigned READ_NUM_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [READ_NUM_WIDTH:0] batch_size,
  input  logic                    output_request,
  output logic                    output_permit,
  input  logic [511:0]            output_data,
  input  logic                    output_valid,
  input  logic                    output_finish,
  output logic                    stall,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [511:0]            wr_data,
  output logic [READ_NUM_WIDTH:0] reads_seen,
  output logic [15:0]             mems_seen,
  output logic                    done,
  output logic [2:0]              err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StWaitReq, StStream, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    permit_q, stall_q;
  logic [READ_NUM_WIDTH:0] batch_q, batch_d;
  logic [READ_NUM_WIDTH:0] reads_q, reads_d;
  logic [15:0]             mems_q, mems_d;
  logic [6:0]              remain_q, remain_d;
  logic                    expect_hdr_q, expect_hdr_d;
  logic [2:0]              err_q, err_d;

  // FIFO storage and bookkeeping. The head address is base + 64 * (lines popped), which
  // equals base + 64 * k for the head beat because beats leave in order and dropped beats
  // never enter, so no per-entry address storage is needed.
  logic [511:0]            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         count_q, count_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;

  logic start_ok, beat_in, full, push, pop, drop;
  logic [6:0] mem_n;

  assign start_ok = start && (state_q == StIdle || state_q == StDone);
  assign beat_in  = output_valid && (state_q == StStream);
  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign wr_valid = (count_q != '0);
  assign pop      = wr_valid && wr_ready;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push     = beat_in && (!full || pop);
  assign drop     = beat_in && full && !pop;
  assign mem_n    = (remain_q >= 7'd2) ? 7'd2 : 7'd1;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_ok) state_d = StWaitReq;
      StWaitReq: if (output_request) state_d = StStream;
      StStream:  if (output_finish) state_d = StDrain;
      StDrain:   if (count_q == '0) state_d = StDone;
      StDone:    if (start_ok) state_d = StWaitReq;
      default:   state_d = StIdle;
    endcase
  end

  // Stream parsing, counters and error flags.
  always_comb begin
    batch_d      = batch_q;
    reads_d      = reads_q;
    mems_d       = mems_q;
    remain_d     = remain_q;
    expect_hdr_d = expect_hdr_q;
    err_d        = err_q;
    rd_addr_d    = rd_addr_q;
    if (start_ok) begin
      batch_d      = batch_size;
      reads_d      = '0;
      mems_d       = '0;
      remain_d     = '0;
      expect_hdr_d = 1'b1;
      err_d        = '0;
      rd_addr_d    = base_addr;
    end else begin
      if (pop) rd_addr_d = rd_addr_q + ADDR_W'(64);
      // Beats are parsed even when dropped so the read/mem sequence stays aligned.
      if (beat_in) begin
        if (expect_hdr_q) begin
          if (output_data[READ_NUM_WIDTH:0] != reads_q) err_d[1] = 1'b1;
          reads_d      = reads_q + 1'b1;
          remain_d     = output_data[70:64];
          expect_hdr_d = (output_data[70:64] == 7'd0);
        end else begin
          mems_d       = mems_q + 16'(mem_n);
          remain_d     = remain_q - mem_n;
          expect_hdr_d = (remain_q == mem_n);
        end
      end
      if (output_valid && state_q != StStream) err_d[0] = 1'b1;
      if (drop) err_d[2] = 1'b1;
      // Judged after any beat arriving alongside finish has been parsed.
      if (state_q == StStream && output_finish && (!expect_hdr_d || reads_d != batch_q)) begin
        err_d[1] = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      permit_q     <= 1'b0;
      stall_q      <= 1'b0;
      batch_q      <= '0;
      reads_q      <= '0;
      mems_q       <= '0;
      remain_q     <= '0;
      expect_hdr_q <= 1'b1;
      err_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      permit_q     <= (state_d == StStream);
      // Two free slots remain when stall rises, absorbing the producer's RAM read latency.
      stall_q      <= (count_d >= CntW'(FIFO_DEPTH - 2));
      batch_q      <= batch_d;
      reads_q      <= reads_d;
      mems_q       <= mems_d;
      remain_q     <= remain_d;
      expect_hdr_q <= expect_hdr_d;
      err_q        <= err_d;
      count_q      <= count_d;
      rd_addr_q    <= rd_addr_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Payload storage carries no reset; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= output_data;
  end

  assign output_permit = permit_q;
  assign stall         = stall_q;
  assign wr_addr       = wr_valid ? rd_addr_q : '0;
  assign wr_data       = wr_valid ? mem_q[rd_ptr_q] : '0;
  assign reads_seen    = reads_q;
  assign mems_seen     = mems_q;
  assign done          = (state_q == StDone);
  assign err           = err_q;

endmodule
